adc_agc_ctrl: RTL and testbench
===============================

Name: adc_agc_ctrl

Overview:
Automatic gain controller for one ADC channel. It sequences the per-channel min/max statistics block through clear/accumulate windows and evaluates the captured signal span. It then steps the analog front-end (attenuator att plus amplifier amp_en) up or down, with a programmable settle period after every change. It sits beside the channel register block; its att/amp_en outputs replace the register-driven ones when AGC is enabled.

Parameters:
CLEAR_CYCLES, 2, cycles stat_cfg is held in clear before each window (>=1)
INIT_IDX, 0, gain index loaded at reset (0..7)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = AGC running, 0 = manual/hold
window_len  in  32  samples per statistics window (0 treated as 1)
hi_thresh  in  8  span above which gain steps down
lo_thresh  in  8  span below which gain steps up
settle_cycles  in  16  wait after a gain change, in clk cycles
manual_we  in  1  load manual_idx (honoured only when enable=0)
manual_idx  in  3  manual gain index
stat_min  in  8  window minimum, two's complement
stat_max  in  8  window maximum, two's complement
stat_count  in  32  samples accumulated in the current window
stat_cfg  out  2  01 = clear/hold, 10 = accumulate
stat_limit  out  32  window limit forwarded to the statistics block
att  out  2  attenuator setting (11 = max attenuation)
amp_en  out  1  front-end amplifier enable
gain_idx  out  3  current gain index, 0 = lowest gain
step_up  out  1  one-cycle pulse on a gain increase
step_dn  out  1  one-cycle pulse on a gain decrease
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values: state IDLE, gain_idx=INIT_IDX, stat_cfg=01, stat_limit=0, step_up=step_dn=0, counters=0.
- att = ~gain_idx[1:0], amp_en = gain_idx[2]. Both are combinational from the registered gain_idx. With INIT_IDX=0, reset gives att=11 and amp_en=0.
- stat_limit is registered from max(window_len,1) every cycle, so it lags window_len by 1 cycle.
- States: IDLE, CLEAR, ACCUM, EVAL, SETTLE.
- IDLE: stat_cfg=01. If enable=1, go to CLEAR next cycle. If enable=0 and manual_we=1, gain_idx<=manual_idx.
- CLEAR: stat_cfg=01 for exactly CLEAR_CYCLES cycles (counter), then go to ACCUM.
- ACCUM: stat_cfg=10. When stat_count >= max(window_len,1), go to EVAL.
- EVAL (exactly 1 cycle): stat_cfg=10, so stats are frozen by the window limit. Compute span = stat_max - stat_min as a 9-bit signed difference, clamped to 0 if negative and to 255 above 255.
  - span > hi_thresh and gain_idx>0: gain_idx-1, step_dn=1 next cycle, go to SETTLE.
  - else span < lo_thresh and gain_idx<7: gain_idx+1, step_up=1 next cycle, go to SETTLE.
  - else no change, go to CLEAR.
  - hi_thresh has priority, so misconfiguration with lo_thresh > hi_thresh is deterministic. At the limits (idx 0 or 7) there is no step and no pulse.
- SETTLE: stat_cfg=01. The counter runs from 0; when count == settle_cycles, go to CLEAR. Dwell is settle_cycles+1 cycles, so settle_cycles=0 gives 1 cycle.
- Latency: att/amp_en change on the cycle after EVAL, coincident with the step pulse.
- enable falling in any non-IDLE state: go to IDLE next cycle. stat_cfg=01 from that cycle, counters clear, gain_idx is held (not reset), and no pulses are issued.
- manual_we is ignored while enable=1, including the cycle enable rises.
- step_up and step_dn are never asserted together.
- Reset mid-operation returns all state to reset values on the next edge.

Test Plan:
1. Reset, then read outputs → gain_idx=0, att=11, amp_en=0, stat_cfg=01, busy=0.
2. enable=1, window_len=100, lo=40, hi=200; stats give min=-10, max=10 (span 20) → CLEAR 2 cycles, ACCUM until count=100, EVAL, step_up pulse; gain_idx=1, att=10; SETTLE lasts settle_cycles+1=5 cycles with settle_cycles=4.
3. gain_idx=7, span 20 repeatedly → no step_up, direct EVAL→CLEAR loop, idx stays 7. Then span=255 (min=-128, max=127) → step_dn, idx=6, att=01, amp_en=1.
4. Span 100, between thresholds → no pulses over 3 windows, gain_idx unchanged, state cycles CLEAR/ACCUM/EVAL.
5. Drop enable during ACCUM and during SETTLE → IDLE next cycle, stat_cfg=01, gain_idx held. manual_we=1 with idx=5 → att=10, amp_en=1. manual_we while enable=1 → ignored.
6. window_len=0 → stat_limit=1, EVAL after stat_count=1. Assert reset during SETTLE → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/adc_agc_ctrl.sv
// adc_agc_ctrl: automatic gain control for one ADC channel; windows the min/max
// statistics block, evaluates signal span and steps the front-end gain index.
module adc_agc_ctrl #(
    parameter int         CLEAR_CYCLES = 2,
    parameter logic [2:0] INIT_IDX     = 3'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] window_len,
    input  logic [7:0]  hi_thresh,
    input  logic [7:0]  lo_thresh,
    input  logic [15:0] settle_cycles,
    input  logic        manual_we,
    input  logic [2:0]  manual_idx,
    input  logic [7:0]  stat_min,
    input  logic [7:0]  stat_max,
    input  logic [31:0] stat_count,
    output logic [1:0]  stat_cfg,
    output logic [31:0] stat_limit,
    output logic [1:0]  att,
    output logic        amp_en,
    output logic [2:0]  gain_idx,
    output logic        step_up,
    output logic        step_dn,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, EVAL, SETTLE} state_t;

    state_t             state, state_n;
    logic [31:0]        cnt, cnt_n, wl;
    logic [2:0]         idx_n;
    logic               up_n, dn_n;
    logic signed [8:0]  diff;
    logic [7:0]         span;

    assign wl = (window_len == 32'd0) ? 32'd1 : window_len;
    // 9-bit difference of two 8-bit signed values never exceeds 255, so only the negative side needs clamping
    assign diff = $signed({stat_max[7], stat_max}) - $signed({stat_min[7], stat_min});
    assign span = diff[8] ? 8'd0 : diff[7:0];
    assign att = ~gain_idx[1:0];
    assign amp_en = gain_idx[2];
    assign busy = state != IDLE;
    assign stat_cfg = (state == ACCUM || state == EVAL) ? 2'b10 : 2'b01;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 32'd0;
            gain_idx <= INIT_IDX;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            stat_limit <= 32'd0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            gain_idx <= idx_n;
            step_up <= up_n;
            step_dn <= dn_n;
            stat_limit <= wl;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n = 32'd0;
        idx_n = gain_idx;
        up_n = 1'b0;
        dn_n = 1'b0;
        // losing enable aborts any activity without touching the gain
        if (state != IDLE && !enable)
            state_n = IDLE;
        else
            case (state)
                IDLE: begin
                    if (enable) state_n = CLEAR;
                    else if (manual_we) idx_n = manual_idx;
                end
                CLEAR: begin
                    if (cnt == 32'(CLEAR_CYCLES - 1)) state_n = ACCUM;
                    else cnt_n = cnt + 32'd1;
                end
                ACCUM: state_n = (stat_count >= wl) ? EVAL : ACCUM;
                EVAL: begin
                    if (span > hi_thresh && gain_idx != 3'd0) begin
                        idx_n = gain_idx - 3'd1;
                        dn_n = 1'b1;
                        state_n = SETTLE;
                    end else if (span < lo_thresh && gain_idx != 3'd7) begin
                        idx_n = gain_idx + 3'd1;
                        up_n = 1'b1;
                        state_n = SETTLE;
                    end else
                        state_n = CLEAR;
                end
                SETTLE: begin
                    if (cnt == {16'd0, settle_cycles}) state_n = CLEAR;
                    else cnt_n = cnt + 32'd1;
                end
                default: state_n = IDLE;
            endcase
    end
endmodule

// File: tb/tb_adc_agc_ctrl.sv
// tb_adc_agc_ctrl: directed and randomized checks of adc_agc_ctrl against a
// countdown-based behavioural model, with an emulated statistics block.
module tb_adc_agc_ctrl;
    localparam int CC = 2;
    localparam int P_IDLE = 0, P_CLEAR = 1, P_ACCUM = 2, P_EVAL = 3, P_SETTLE = 4;

    logic        clk = 0, reset = 1, enable = 0, manual_we = 0;
    logic [31:0] window_len = 100, stat_count = 0;
    logic [7:0]  hi_thresh = 200, lo_thresh = 40, stat_min = 8'hF6, stat_max = 8'd10;
    logic [15:0] settle_cycles = 4;
    logic [2:0]  manual_idx = 0;
    logic [1:0]  stat_cfg, att;
    logic [31:0] stat_limit;
    logic        amp_en, step_up, step_dn, busy;
    logic [2:0]  gain_idx;

    int checks = 0, errors = 0;
    bit mon = 0;
    int m_ph = P_IDLE, m_left = 0, m_idx = 0;
    bit m_up = 0, m_dn = 0;
    logic [31:0] m_lim = 0;

    always #5 clk = ~clk;

    adc_agc_ctrl #(.CLEAR_CYCLES(CC), .INIT_IDX(3'd0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .window_len(window_len),
        .hi_thresh(hi_thresh), .lo_thresh(lo_thresh), .settle_cycles(settle_cycles),
        .manual_we(manual_we), .manual_idx(manual_idx), .stat_min(stat_min),
        .stat_max(stat_max), .stat_count(stat_count), .stat_cfg(stat_cfg),
        .stat_limit(stat_limit), .att(att), .amp_en(amp_en), .gain_idx(gain_idx),
        .step_up(step_up), .step_dn(step_dn), .busy(busy)
    );

    // statistics block: counts samples while accumulating, cleared otherwise
    always @(posedge clk) stat_count <= (reset || stat_cfg != 2'b10) ? 32'd0 : stat_count + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int span_of(input logic [7:0] mx, input logic [7:0] mn);
        int s;
        s = int'($signed(mx)) - int'($signed(mn));
        return s < 0 ? 0 : (s > 255 ? 255 : s);
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] wl;
        int sp;
        wl = (window_len == 0) ? 32'd1 : window_len;
        m_up = 0;
        m_dn = 0;
        if (reset) begin
            m_ph = P_IDLE;
            m_idx = 0;
            m_lim = 0;
            m_left = 0;
        end else begin
            m_lim = wl;
            if (m_ph != P_IDLE && !enable) m_ph = P_IDLE;
            else if (m_ph == P_IDLE) begin
                if (enable) begin m_ph = P_CLEAR; m_left = CC; end
                else if (manual_we) m_idx = int'(manual_idx);
            end else if (m_ph == P_CLEAR) begin
                m_left--;
                if (m_left == 0) m_ph = P_ACCUM;
            end else if (m_ph == P_ACCUM) begin
                if (stat_count >= wl) m_ph = P_EVAL;
            end else if (m_ph == P_EVAL) begin
                sp = span_of(stat_max, stat_min);
                if (sp > int'(hi_thresh) && m_idx > 0) begin
                    m_idx--; m_dn = 1; m_ph = P_SETTLE; m_left = int'(settle_cycles) + 1;
                end else if (sp < int'(lo_thresh) && m_idx < 7) begin
                    m_idx++; m_up = 1; m_ph = P_SETTLE; m_left = int'(settle_cycles) + 1;
                end else begin
                    m_ph = P_CLEAR; m_left = CC;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin m_ph = P_CLEAR; m_left = CC; end
            end
        end
        #1;
        if (mon) begin
            chk("cfg", stat_cfg, (m_ph == P_ACCUM || m_ph == P_EVAL) ? 2 : 1);
            chk("idx", gain_idx, m_idx);
            chk("att", att, 3 - (m_idx % 4));
            chk("amp_en", amp_en, m_idx / 4);
            chk("step_up", step_up, m_up);
            chk("step_dn", step_dn, m_dn);
            chk("busy", busy, m_ph != P_IDLE);
            chk("limit", stat_limit, m_lim);
            chk("excl", step_up & step_dn, 0);
        end
    end

    task automatic wait_pulse(input bit dn, output int n, output bit seen);
        n = 0;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            n++;
            if (dn ? step_dn : step_up) begin seen = 1; return; end
        end
    endtask

    initial begin
        int n, k;
        bit seen;
        repeat (2) @(negedge clk);
        mon = 1;
        chk("rst_idx", gain_idx, 0);
        chk("rst_att", att, 3);
        chk("rst_amp", amp_en, 0);
        chk("rst_cfg", stat_cfg, 1);
        chk("rst_busy", busy, 0);
        chk("rst_limit", stat_limit, 0);
        reset = 0;
        @(negedge clk);
        enable = 1;
        wait_pulse(0, n, seen);
        chk("t2_seen", seen, 1);
        chk("t2_latency", n, 105);
        chk("t2_idx", gain_idx, 1);
        chk("t2_att", att, 2);
        k = 1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            if (stat_cfg != 2'b01) break;
            k++;
        end
        chk("t2_settle_clear", k, 7);
        @(negedge clk); enable = 0;
        @(negedge clk); manual_we = 1; manual_idx = 7;
        @(negedge clk); manual_idx = 3; enable = 1; window_len = 10;
        @(negedge clk); manual_we = 0;
        chk("t5_we_ignored", gain_idx, 7);
        repeat (60) @(negedge clk);
        chk("t3_hold7", gain_idx, 7);
        stat_min = 8'h80; stat_max = 8'h7F;
        wait_pulse(1, n, seen);
        chk("t3_dn_seen", seen, 1);
        chk("t3_idx", gain_idx, 6);
        chk("t3_att", att, 1);
        chk("t3_amp", amp_en, 1);
        stat_min = 8'd0; stat_max = 8'd100;
        repeat (60) @(negedge clk);
        chk("t4_hold6", gain_idx, 6);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stat_cfg == 2'b10) break;
        end
        enable = 0;
        @(negedge clk);
        chk("t5_accum_busy", busy, 0);
        chk("t5_accum_cfg", stat_cfg, 1);
        chk("t5_accum_idx", gain_idx, 6);
        lo_thresh = 200; hi_thresh = 250; enable = 1;
        wait_pulse(0, n, seen);
        chk("t5_up_seen", seen, 1);
        enable = 0;
        @(posedge clk); #2;
        chk("t5_settle_busy", busy, 0);
        chk("t5_settle_idx", gain_idx, 7);
        chk("t5_settle_up", step_up, 0);
        manual_we = 1; manual_idx = 5;
        @(posedge clk); #2;
        manual_we = 0;
        chk("t5_man_att", att, 2);
        chk("t5_man_amp", amp_en, 1);
        window_len = 0;
        @(posedge clk); #2;
        chk("t6_limit", stat_limit, 1);
        enable = 1;
        wait_pulse(0, n, seen);
        chk("t6_latency", n, 6);
        reset = 1;
        @(posedge clk); #2;
        chk("t6_rst_idx", gain_idx, 0);
        chk("t6_rst_att", att, 3);
        chk("t6_rst_cfg", stat_cfg, 1);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_up", step_up, 0);
        reset = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                enable = ~enable;
                if (!enable) begin
                    settle_cycles = 16'($urandom_range(0, 6));
                    window_len = $urandom_range(0, 12);
                end
            end
            if (i % 50 == 0) begin
                hi_thresh = 8'($urandom_range(0, 255));
                lo_thresh = 8'($urandom_range(0, 255));
            end
            reset = ($urandom_range(0, 299) == 0);
            manual_we = ($urandom_range(0, 3) == 0);
            manual_idx = 3'($urandom_range(0, 7));
            stat_min = 8'($urandom);
            stat_max = 8'($urandom);
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
